imem_boot_ctrl: RTL

Boot and run-control sequencer for the `moka_top` pipelined RV32 core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into instruction memory through the core's `instr_mem_address`, `instr_mem_write_data` and `instr_mem_we` ports. Once loading is complete it releases the core from reset and drives its `en`. While the core runs, it supports pause, abort and cycle counting. It sits between the host/testbench loader and the core top level.

---
 rtl/imem_boot_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot/run-control sequencer: streams a program into instruction memory, then
// releases the core from reset and gates its enable (pause, abort, cycle count).
module imem_boot_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [15:0]           length,
    input  logic                  abort,
    input  logic                  halt,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] instr_mem_address,
    output logic [DATA_WIDTH-1:0] instr_mem_write_data,
    output logic                  instr_mem_we,
    output logic                  core_rstn,
    output logic                  core_en,
    output logic                  busy,
    output logic                  error,
    output logic [31:0]           cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             idx_q, idx_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    core_rstn_q, core_rstn_d;
    logic                    core_en_q, core_en_d;
    logic                    busy_q, busy_d;
    logic                    hs;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        s_ready = (state_q == S_LOAD) && !abort;
        hs      = s_ready && s_valid;

        if (state_q == S_RUN) cnt_d = cnt_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0 && 32'(length) <= MEM_WORDS) begin
                        len_d   = length;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    we_d   = 1'b1;
                    addr_d = DATA_WIDTH'({idx_q, 2'b00});
                    data_d = s_data;
                    idx_d  = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_RUN;
            S_RUN:     if (halt) state_d = S_PAUSE;
            S_PAUSE:   if (!halt) state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase

        // Abort wins over halt and over any handshake offered this cycle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
        end

        // Control outputs are registered copies of the next state's decode.
        core_rstn_d = (state_d == S_RELEASE) || (state_d == S_RUN) || (state_d == S_PAUSE);
        core_en_d   = (state_d == S_RUN);
        busy_d      = (state_d == S_LOAD) || (state_d == S_RELEASE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            core_rstn_q <= 1'b0;
            core_en_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            core_rstn_q <= core_rstn_d;
            core_en_q   <= core_en_d;
            busy_q      <= busy_d;
        end
    end

    assign instr_mem_address    = addr_q;
    assign instr_mem_write_data = data_q;
    assign instr_mem_we         = we_q;
    assign core_rstn            = core_rstn_q;
    assign core_en              = core_en_q;
    assign busy                 = busy_q;
    assign error                = err_q;
    assign cycle_count          = cnt_q;

endmodule
